// File: rtl/impulse_pkg.sv
// Shared constants and the quadrature step decoder for the impulse counter front end.
package impulse_pkg;

    localparam logic MODE_PULSE = 1'b0;
    localparam logic MODE_QUAD  = 1'b1;
    localparam logic DIR_UP     = 1'b1;
    localparam logic DIR_DOWN   = 1'b0;

    localparam logic [1:0] Q00 = 2'b00;
    localparam logic [1:0] Q10 = 2'b10;
    localparam logic [1:0] Q11 = 2'b11;
    localparam logic [1:0] Q01 = 2'b01;

    typedef struct packed {
        logic valid;
        logic illegal;
        logic dir;
    } quad_step_t;

    // Forward Gray order is 00 -> 10 -> 11 -> 01 -> 00, with Q = {A, B}.
    function automatic quad_step_t quad_step(logic [1:0] prev, logic [1:0] cur);
        quad_step_t r;
        r = '0;
        case ({prev, cur})
            {Q00, Q10}, {Q10, Q11}, {Q11, Q01}, {Q01, Q00}: begin
                r.valid = 1'b1;
                r.dir   = DIR_UP;
            end
            {Q00, Q01}, {Q01, Q11}, {Q11, Q10}, {Q10, Q00}: begin
                r.valid = 1'b1;
                r.dir   = DIR_DOWN;
            end
            {Q00, Q11}, {Q11, Q00}, {Q01, Q10}, {Q10, Q01}: begin
                r.illegal = 1'b1;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/impulse_conditioner_if.sv
// Raw inputs, controls and conditioned outputs of the impulse conditioner.
interface impulse_conditioner_if;

    logic IN_A;
    logic IN_B;
    logic MODE;
    logic CLR_ERR;
    logic EN;
    logic DIR;
    logic ERR;
    logic A_CLEAN;
    logic B_CLEAN;

    modport master (
        output IN_A, IN_B, MODE, CLR_ERR,
        input  EN, DIR, ERR, A_CLEAN, B_CLEAN
    );

    modport slave (
        input  IN_A, IN_B, MODE, CLR_ERR,
        output EN, DIR, ERR, A_CLEAN, B_CLEAN
    );

endinterface

// File: rtl/debounce_filter.sv
// One channel: synchroniser chain, then a run-length debouncer feeding the clean level.
module debounce_filter #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic clean
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   clean_q, clean_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], raw};
        cnt_d   = cnt_q;
        clean_d = clean_q;
        if (s == clean_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            // Enough consecutive differing samples: accept the new level.
            clean_d = s;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            clean_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
        end
    end

    assign clean = clean_q;

endmodule

// File: rtl/impulse_conditioner.sv
// Conditions two raw pulse/encoder lines into a one-cycle EN strobe plus DIR
// for the BCD impulse counter, with a sticky illegal-transition flag.
module impulse_conditioner
    import impulse_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int QUAD_X4         = 0
) (
    input  logic           CLK,
    input  logic           RST,
    impulse_conditioner_if.slave bus
);

    logic       a_clean;
    logic       b_clean;
    logic [1:0] q;
    logic [1:0] prev_q, prev_d;
    logic       en_q, en_d;
    logic       dir_q, dir_d;
    logic       err_q, err_d;
    quad_step_t step;

    debounce_filter #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb_a (
        .clk   (CLK),
        .rst   (RST),
        .raw   (bus.IN_A),
        .clean (a_clean)
    );

    debounce_filter #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb_b (
        .clk   (CLK),
        .rst   (RST),
        .raw   (bus.IN_B),
        .clean (b_clean)
    );

    assign q    = {a_clean, b_clean};
    assign step = quad_step(prev_q, q);

    always_comb begin
        prev_d = q;
        en_d   = 1'b0;
        dir_d  = dir_q;
        err_d  = err_q;
        if (bus.MODE == MODE_QUAD) begin
            // x1 resolution only counts on leaving the 00 state.
            en_d = step.valid && ((QUAD_X4 != 0) || (prev_q == Q00));
            if (en_d) dir_d = step.dir;
        end else begin
            en_d = !prev_q[1] && q[1];
            if (en_d) dir_d = b_clean;
        end
        if ((bus.MODE == MODE_QUAD) && step.illegal) begin
            err_d = 1'b1;
        end else if (bus.CLR_ERR) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prev_q <= Q00;
            en_q   <= 1'b0;
            dir_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            prev_q <= prev_d;
            en_q   <= en_d;
            dir_q  <= dir_d;
            err_q  <= err_d;
        end
    end

    assign bus.EN      = en_q;
    assign bus.DIR     = dir_q;
    assign bus.ERR     = err_q;
    assign bus.A_CLEAN = a_clean;
    assign bus.B_CLEAN = b_clean;

endmodule

// File: tb/tb_impulse_conditioner.sv
// Bench for impulse_conditioner: x4 and x1 instances driven in parallel and
// compared every cycle against a window-based behavioural model.
module tb_impulse_conditioner;

    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_a = 1'b0, in_b = 1'b0, in_mode = 1'b0, in_clr = 1'b0;

    int errors = 0;
    int checks = 0;

    impulse_conditioner_if bus4 ();
    impulse_conditioner_if bus1 ();

    assign bus4.IN_A = in_a;
    assign bus4.IN_B = in_b;
    assign bus4.MODE = in_mode;
    assign bus4.CLR_ERR = in_clr;
    assign bus1.IN_A = in_a;
    assign bus1.IN_B = in_b;
    assign bus1.MODE = in_mode;
    assign bus1.CLR_ERR = in_clr;

    impulse_conditioner #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .QUAD_X4(1)
    ) dut4 (.CLK(clk), .RST(rst), .bus(bus4.slave));

    impulse_conditioner #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .QUAD_X4(0)
    ) dut1 (.CLK(clk), .RST(rst), .bus(bus1.slave));

    always #5 clk = ~clk;

    // Model: raw delay line, window of synchronised samples, clean levels, outputs.
    bit da[SYNC];
    bit db[SYNC];
    bit ha[$];
    bit hb[$];
    bit ca, cb;
    bit [1:0] mprev;
    bit men4, mdir4, merr4, men1, mdir1, merr1;

    function automatic int pos(bit [1:0] v);
        case (v)
            2'b00: return 0;
            2'b10: return 1;
            2'b11: return 2;
            default: return 3;
        endcase
    endfunction

    function automatic bit all_eq(bit h[$], bit v);
        foreach (h[i]) if (h[i] != v) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < SYNC; i++) begin
            da[i] = 1'b0;
            db[i] = 1'b0;
        end
        ha = {};
        hb = {};
        for (int i = 0; i < DEB; i++) begin
            ha.push_back(1'b0);
            hb.push_back(1'b0);
        end
        ca = 0; cb = 0; mprev = 2'b00;
        men4 = 0; mdir4 = 0; merr4 = 0;
        men1 = 0; mdir1 = 0; merr1 = 0;
    endtask

    task automatic model_step(bit a, bit b, bit mode, bit clr);
        bit [1:0] q;
        int d;
        bit ill;
        q = {ca, cb};
        d = (pos(q) - pos(mprev)) & 3;
        if (!mode) begin
            men4 = !mprev[1] && q[1];
            men1 = men4;
            if (men4) begin
                mdir4 = cb;
                mdir1 = cb;
            end
        end else begin
            men4 = (d == 1) || (d == 3);
            men1 = men4 && (mprev == 2'b00);
            if (men4) mdir4 = (d == 1);
            if (men1) mdir1 = (d == 1);
        end
        ill = mode && (d == 2);
        merr4 = ill ? 1'b1 : (clr ? 1'b0 : merr4);
        merr1 = ill ? 1'b1 : (clr ? 1'b0 : merr1);
        mprev = q;
        ha.push_front(da[SYNC-1]);
        void'(ha.pop_back());
        hb.push_front(db[SYNC-1]);
        void'(hb.pop_back());
        if (all_eq(ha, !ca)) ca = !ca;
        if (all_eq(hb, !cb)) cb = !cb;
        for (int i = SYNC - 1; i > 0; i--) begin
            da[i] = da[i-1];
            db[i] = db[i-1];
        end
        da[0] = a;
        db[0] = b;
    endtask

    function automatic logic [9:0] obs_v();
        return {bus4.EN, bus4.DIR, bus4.ERR, bus4.A_CLEAN, bus4.B_CLEAN,
                bus1.EN, bus1.DIR, bus1.ERR, bus1.A_CLEAN, bus1.B_CLEAN};
    endfunction

    function automatic logic [9:0] exp_v();
        return {men4, mdir4, merr4, ca, cb, men1, mdir1, merr1, ca, cb};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step(in_a, in_b, in_mode, in_clr);
        #1;
    endtask

    task automatic test_reset();
        in_a = 1; in_b = 1; in_mode = 0; in_clr = 0;
        rst = 1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs_v() !== 10'b0) begin
            errors++;
            $display("FAIL reset_hold got=%b exp=%b", obs_v(), 10'b0);
        end
        rst = 0;
        checks++;
        if (obs_v() !== 10'b0) begin
            errors++;
            $display("FAIL reset_release got=%b exp=%b", obs_v(), 10'b0);
        end
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++;
            if (obs_v() !== exp_v()) begin
                errors++;
                $display("FAIL reset_model edge=%0d got=%b exp=%b", i, obs_v(), exp_v());
            end
            if (i == 5) begin
                checks++;
                if (bus4.A_CLEAN !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_clean_early got=%b exp=0", bus4.A_CLEAN);
                end
            end
            if (i == 6) begin
                checks++;
                if ({bus4.A_CLEAN, bus4.B_CLEAN} !== 2'b11) begin
                    errors++;
                    $display("FAIL reset_clean6 got=%b exp=11", {bus4.A_CLEAN, bus4.B_CLEAN});
                end
            end
            if (i == 7) begin
                checks++;
                if ({bus4.EN, bus4.DIR, bus1.EN} !== 3'b111) begin
                    errors++;
                    $display("FAIL reset_en7 got=%b exp=111", {bus4.EN, bus4.DIR, bus1.EN});
                end
            end
            if (i == 8) begin
                checks++;
                if (bus4.EN !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_en8 got=%b exp=0", bus4.EN);
                end
            end
        end
    endtask

    task automatic test_pulse();
        int first;
        int n;
        int digit;
        in_mode = 0; in_b = 1; in_a = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (obs_v() !== exp_v()) begin
                errors++;
                $display("FAIL pulse_fall cyc=%0d got=%b exp=%b", i, obs_v(), exp_v());
            end
        end
        in_a = 1;
        first = 0;
        n = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            checks++;
            if (obs_v() !== exp_v()) begin
                errors++;
                $display("FAIL pulse_rise cyc=%0d got=%b exp=%b", i, obs_v(), exp_v());
            end
            if (bus4.EN === 1'b1) begin
                n++;
                if (first == 0) first = i;
            end
        end
        checks++;
        if (first != 7 || n != 1 || bus4.DIR !== 1'b1) begin
            errors++;
            $display("FAIL pulse_latency got edge=%0d n=%0d dir=%b exp edge=7 n=1 dir=1",
                     first, n, bus4.DIR);
        end
        n = 0;
        digit = 0;
        for (int p = 0; p < 10; p++) begin
            for (int h = 0; h < 16; h++) begin
                in_a = (h >= 8);
                tick();
                checks++;
                if (obs_v() !== exp_v()) begin
                    errors++;
                    $display("FAIL pulse_train p=%0d h=%0d got=%b exp=%b", p, h, obs_v(), exp_v());
                end
                if (bus4.EN === 1'b1) begin
                    n++;
                    digit = (digit + 1) % 10;
                end
            end
        end
        in_a = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus4.EN === 1'b1) begin
                n++;
                digit = (digit + 1) % 10;
            end
        end
        checks++;
        if (n != 10 || digit != 0) begin
            errors++;
            $display("FAIL pulse_count got n=%0d bcd=%0d exp n=10 bcd=0", n, digit);
        end
    endtask

    task automatic test_glitch();
        int seen_clean;
        int n;
        in_mode = 0; in_a = 0;
        seen_clean = 0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            in_a = (i >= 2 && i < 5);
            tick();
            checks++;
            if (obs_v() !== exp_v()) begin
                errors++;
                $display("FAIL glitch3 cyc=%0d got=%b exp=%b", i, obs_v(), exp_v());
            end
            if (bus4.A_CLEAN === 1'b1) seen_clean++;
            if (bus4.EN === 1'b1) n++;
        end
        checks++;
        if (seen_clean != 0 || n != 0) begin
            errors++;
            $display("FAIL glitch3_reject got clean=%0d en=%0d exp 0 0", seen_clean, n);
        end
        seen_clean = 0;
        for (int i = 0; i < 24; i++) begin
            in_a = (i >= 2 && i < 6);
            tick();
            checks++;
            if (obs_v() !== exp_v()) begin
                errors++;
                $display("FAIL glitch4 cyc=%0d got=%b exp=%b", i, obs_v(), exp_v());
            end
            if (bus4.A_CLEAN === 1'b1) seen_clean++;
            if (bus4.EN === 1'b1) n++;
        end
        checks++;
        if (seen_clean == 0 || n != 1) begin
            errors++;
            $display("FAIL glitch4_accept got clean=%0d en=%0d exp >0 1", seen_clean, n);
        end
    endtask

    task automatic test_quad();
        logic [1:0] fwd[4];
        logic [1:0] rev[4];
        int n4, n1;
        fwd = '{2'b10, 2'b11, 2'b01, 2'b00};
        rev = '{2'b01, 2'b11, 2'b10, 2'b00};
        in_a = 0; in_b = 0; in_mode = 0;
        for (int i = 0; i < 12; i++) tick();
        in_mode = 1;
        for (int dir = 1; dir >= 0; dir--) begin
            n4 = 0;
            n1 = 0;
            for (int s = 0; s < 4; s++) begin
                {in_a, in_b} = dir ? fwd[s] : rev[s];
                for (int h = 0; h < 10; h++) begin
                    tick();
                    checks++;
                    if (obs_v() !== exp_v()) begin
                        errors++;
                        $display("FAIL quad d=%0d s=%0d h=%0d got=%b exp=%b",
                                 dir, s, h, obs_v(), exp_v());
                    end
                    if (bus4.EN === 1'b1) begin
                        n4++;
                        checks++;
                        if (bus4.DIR !== dir[0]) begin
                            errors++;
                            $display("FAIL quad_dir4 got=%b exp=%b", bus4.DIR, dir[0]);
                        end
                    end
                    if (bus1.EN === 1'b1) begin
                        n1++;
                        checks++;
                        if (bus1.DIR !== dir[0]) begin
                            errors++;
                            $display("FAIL quad_dir1 got=%b exp=%b", bus1.DIR, dir[0]);
                        end
                    end
                end
            end
            checks++;
            if (n4 != 4 || n1 != 1) begin
                errors++;
                $display("FAIL quad_count d=%0d got x4=%0d x1=%0d exp 4 1", dir, n4, n1);
            end
        end
    endtask

    task automatic test_illegal();
        int n;
        in_mode = 1; in_clr = 0;
        n = 0;
        {in_a, in_b} = 2'b11;
        for (int i = 1; i <= 17; i++) begin
            tick();
            checks++;
            if (obs_v() !== exp_v()) begin
                errors++;
                $display("FAIL illegal cyc=%0d got=%b exp=%b", i, obs_v(), exp_v());
            end
            if (bus4.EN === 1'b1 || bus1.EN === 1'b1) n++;
        end
        checks++;
        if (n != 0 || {bus4.ERR, bus1.ERR} !== 2'b11) begin
            errors++;
            $display("FAIL illegal_set got en=%0d err=%b exp en=0 err=11", n, {bus4.ERR, bus1.ERR});
        end
        in_clr = 1;
        tick();
        in_clr = 0;
        checks++;
        if ({bus4.ERR, bus1.ERR} !== 2'b00) begin
            errors++;
            $display("FAIL illegal_clear got=%b exp=00", {bus4.ERR, bus1.ERR});
        end
        {in_a, in_b} = 2'b00;
        in_clr = 1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            checks++;
            if (obs_v() !== exp_v()) begin
                errors++;
                $display("FAIL illegal_clr cyc=%0d got=%b exp=%b", i, obs_v(), exp_v());
            end
        end
        checks++;
        if ({bus4.ERR, bus1.ERR} !== 2'b11) begin
            errors++;
            $display("FAIL illegal_priority got=%b exp=11", {bus4.ERR, bus1.ERR});
        end
        in_clr = 0;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if ({bus4.ERR, bus1.ERR} !== 2'b11) begin
            errors++;
            $display("FAIL illegal_sticky got=%b exp=11", {bus4.ERR, bus1.ERR});
        end
    endtask

    task automatic test_reset_mid();
        int n;
        in_mode = 0; in_a = 0; in_b = 1;
        for (int i = 0; i < 12; i++) tick();
        in_a = 1;
        for (int i = 0; i < 5; i++) tick();
        #2;
        rst = 1;
        model_reset();
        #1;
        checks++;
        if (obs_v() !== 10'b0) begin
            errors++;
            $display("FAIL reset_async got=%b exp=%b", obs_v(), 10'b0);
        end
        in_a = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        n = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            checks++;
            if (obs_v() !== exp_v()) begin
                errors++;
                $display("FAIL reset_mid cyc=%0d got=%b exp=%b", i, obs_v(), exp_v());
            end
            if (bus4.EN === 1'b1) n++;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL reset_mid_en got=%0d exp=0", n);
        end
        for (int i = 0; i < 30; i++) begin
            in_mode = (i < 10) ? 1'b1 : ((i < 20) ? 1'b0 : 1'b1);
            tick();
            checks++;
            if (obs_v() !== exp_v()) begin
                errors++;
                $display("FAIL mode_switch cyc=%0d got=%b exp=%b", i, obs_v(), exp_v());
            end
            if (bus4.EN === 1'b1 || bus1.EN === 1'b1) n++;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL mode_switch_en got=%0d exp=0", n);
        end
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                in_a = 1'($urandom_range(0, 1));
                in_b = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 7) == 0) in_mode = ~in_mode;
                hold = $urandom_range(1, 9);
            end
            hold--;
            in_clr = ($urandom_range(0, 15) == 0);
            tick();
            checks++;
            if (obs_v() !== exp_v()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%b exp=%b", i, obs_v(), exp_v());
            end
        end
        in_clr = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_pulse();
        test_glitch();
        test_quad();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
